// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and the word-addressed data memory.
// Queues word stores, drains them in idle load cycles, forwards to loads.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    output logic             st_ready,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    output logic [31:0]      ld_data,
    output logic             ld_fwd,
    output logic [31:0]      MemAddr,
    output logic [31:0]      Memdata,
    output logic             MemWrite,
    input  logic [31:0]      Memout,
    output logic             sb_empty,
    output logic [PTR_W:0]   sb_count
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);

    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic full;
    logic enq;
    logic drain;

    assign full     = (count_q == CNT_MAX);
    assign sb_empty = (count_q == '0);
    assign sb_count = count_q;
    assign st_ready = !full;

    assign enq   = st_valid && !full;
    assign drain = !sb_empty && !ld_valid && !reset;

    // Loads own the read port; drain only when the port is free.
    always_comb begin
        MemAddr  = 32'h0;
        Memdata  = 32'h0;
        MemWrite = 1'b0;
        if (ld_valid) begin
            MemAddr = ld_addr;
        end else if (drain) begin
            MemAddr  = {addr_q[head_q], 2'b00};
            Memdata  = data_q[head_q];
            MemWrite = 1'b1;
        end
    end

    // Walk oldest to youngest so the last hit is the youngest match.
    logic [PTR_W-1:0] idx;
    logic             hit;
    logic [31:0]      hit_data;

    always_comb begin
        idx      = head_q;
        hit      = 1'b0;
        hit_data = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (((PTR_W+1)'(i) < count_q) &&
                (addr_q[idx] == ld_addr[31:2])) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    assign ld_fwd  = hit;
    assign ld_data = hit ? hit_data : Memout;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            tail_d = tail_q + PTR_ONE;
        end
        if (drain) begin
            head_d = head_q + PTR_ONE;
        end
        unique case ({enq, drain})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (enq) begin
            addr_q[tail_q] <= st_addr[31:2];
            data_q[tail_q] <= st_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a small behavioural data memory.
// Each scenario task drives vectors and checks hand-computed values.
module tb_store_buffer;

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        st_ready;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data;
    logic        ld_fwd;
    logic [31:0] MemAddr;
    logic [31:0] Memdata;
    logic        MemWrite;
    logic [31:0] Memout;
    logic        sb_empty;
    logic [2:0]  sb_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [256];
    bit          written [256];
    logic [63:0] wlog [$];

    store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .Clk(Clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_fwd(ld_fwd),
        .MemAddr(MemAddr), .Memdata(Memdata), .MemWrite(MemWrite),
        .Memout(Memout),
        .sb_empty(sb_empty), .sb_count(sb_count)
    );

    always #5 Clk = ~Clk;

    // Unwritten words read back a recognisable address-tagged pattern.
    assign Memout = written[MemAddr[9:2]] ? mem[MemAddr[9:2]]
                                          : {16'hF00D, MemAddr[15:0]};

    always @(posedge Clk) begin
        if (MemWrite) begin
            mem[MemAddr[9:2]]     <= Memdata;
            written[MemAddr[9:2]] <= 1'b1;
            wlog.push_back({MemAddr, Memdata});
        end
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if (MemWrite !== 1'b0) begin
            failures++;
            $display("FAIL rst_memwrite: got %0b exp 0", MemWrite);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (sb_empty !== 1'b1 || st_ready !== 1'b1 ||
                MemWrite !== 1'b0 || sb_count !== 3'd0) begin
                failures++;
                $display("FAIL idle_state: empty=%0b ready=%0b wr=%0b cnt=%0d exp 1 1 0 0",
                         sb_empty, st_ready, MemWrite, sb_count);
            end
            tick();
        end
        ld_valid = 1'b1;
        ld_addr  = 32'h100;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1;
            st_addr  = 32'h40 + 32'(4 * i);
            st_data  = 32'h900 + 32'(i);
            tick();
        end
        st_valid = 1'b0;
        #1;
        checks++;
        if (sb_count !== 3'd3) begin
            failures++;
            $display("FAIL rst_fill_cnt: got %0d exp 3", sb_count);
        end
        wlog.delete();
        reset    = 1'b1;
        ld_valid = 1'b0;
        #1;
        checks++;
        if (MemWrite !== 1'b0) begin
            failures++;
            $display("FAIL rst_force_wr: got %0b exp 0", MemWrite);
        end
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (wlog.size() != 0 || sb_empty !== 1'b1) begin
            failures++;
            $display("FAIL rst_discard: writes=%0d empty=%0b exp 0 1",
                     wlog.size(), sb_empty);
        end
    endtask

    task automatic test_single_store;
        wlog.delete();
        st_valid = 1'b1;
        st_addr  = 32'h10;
        st_data  = 32'hDEADBEEF;
        #1;
        checks++;
        if (MemWrite !== 1'b0) begin
            failures++;
            $display("FAIL single_early: MemWrite=%0b exp 0", MemWrite);
        end
        tick();
        st_valid = 1'b0;
        #1;
        checks++;
        if (MemWrite !== 1'b1 || MemAddr !== 32'h10 ||
            Memdata !== 32'hDEADBEEF || sb_count !== 3'd1) begin
            failures++;
            $display("FAIL single_drain: wr=%0b addr=%h data=%h cnt=%0d exp 1 00000010 deadbeef 1",
                     MemWrite, MemAddr, Memdata, sb_count);
        end
        tick();
        checks++;
        if (sb_empty !== 1'b1 || MemWrite !== 1'b0 || MemAddr !== 32'h0) begin
            failures++;
            $display("FAIL single_after: empty=%0b wr=%0b addr=%h exp 1 0 0",
                     sb_empty, MemWrite, MemAddr);
        end
    endtask

    task automatic test_fill;
        ld_valid = 1'b1;
        ld_addr  = 32'h200;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1;
            st_addr  = 32'(4 * i);
            st_data  = 32'hA0 + 32'(i);
            tick();
        end
        st_addr = 32'h30;
        st_data = 32'hBAD;
        #1;
        checks++;
        if (st_ready !== 1'b0 || sb_count !== 3'd4) begin
            failures++;
            $display("FAIL full_flag: ready=%0b cnt=%0d exp 0 4", st_ready, sb_count);
        end
        checks++;
        if (MemAddr !== 32'h200 || MemWrite !== 1'b0) begin
            failures++;
            $display("FAIL load_port: addr=%h wr=%0b exp 00000200 0", MemAddr, MemWrite);
        end
        tick();
        st_valid = 1'b0;
        #1;
        checks++;
        if (sb_count !== 3'd4) begin
            failures++;
            $display("FAIL full_ignore: cnt=%0d exp 4", sb_count);
        end
        wlog.delete();
        ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (MemWrite !== 1'b1 || MemAddr !== 32'(4 * i) ||
                Memdata !== 32'hA0 + 32'(i)) begin
                failures++;
                $display("FAIL fill_order%0d: wr=%0b addr=%h data=%h exp 1 %h %h",
                         i, MemWrite, MemAddr, Memdata, 32'(4 * i), 32'hA0 + 32'(i));
            end
            tick();
        end
        checks++;
        if (sb_empty !== 1'b1 || wlog.size() != 4) begin
            failures++;
            $display("FAIL fill_done: empty=%0b writes=%0d exp 1 4", sb_empty, wlog.size());
        end
    endtask

    task automatic test_forwarding;
        ld_valid = 1'b1;
        ld_addr  = 32'h300;
        st_valid = 1'b1;
        st_addr  = 32'h20;
        st_data  = 32'h1111;
        tick();
        st_data = 32'h2222;
        tick();
        st_valid = 1'b0;
        ld_addr  = 32'h22;
        #1;
        checks++;
        if (ld_fwd !== 1'b1 || ld_data !== 32'h2222) begin
            failures++;
            $display("FAIL fwd_hit: fwd=%0b data=%h exp 1 00002222", ld_fwd, ld_data);
        end
        ld_addr = 32'h24;
        #1;
        checks++;
        if (ld_fwd !== 1'b0 || ld_data !== 32'hF00D0024) begin
            failures++;
            $display("FAIL fwd_miss: fwd=%0b data=%h exp 0 f00d0024", ld_fwd, ld_data);
        end
        ld_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (sb_empty !== 1'b1 || mem[8] !== 32'h2222) begin
            failures++;
            $display("FAIL fwd_drain: empty=%0b mem20=%h exp 1 00002222", sb_empty, mem[8]);
        end
    endtask

    task automatic test_simultaneous;
        ld_valid = 1'b1;
        ld_addr  = 32'h300;
        st_valid = 1'b1;
        st_addr  = 32'h50;
        st_data  = 32'h1;
        tick();
        st_addr = 32'h54;
        st_data = 32'h2;
        tick();
        ld_valid = 1'b0;
        st_addr  = 32'h58;
        st_data  = 32'h3;
        #1;
        checks++;
        if (MemWrite !== 1'b1 || MemAddr !== 32'h50 || Memdata !== 32'h1 ||
            st_ready !== 1'b1 || sb_count !== 3'd2) begin
            failures++;
            $display("FAIL simul_head: wr=%0b addr=%h data=%h ready=%0b cnt=%0d exp 1 00000050 1 1 2",
                     MemWrite, MemAddr, Memdata, st_ready, sb_count);
        end
        tick();
        st_valid = 1'b0;
        #1;
        checks++;
        if (sb_count !== 3'd2 || MemAddr !== 32'h54) begin
            failures++;
            $display("FAIL simul_count: cnt=%0d addr=%h exp 2 00000054", sb_count, MemAddr);
        end
        tick();
        checks++;
        if (MemAddr !== 32'h58 || Memdata !== 32'h3) begin
            failures++;
            $display("FAIL simul_tail: addr=%h data=%h exp 00000058 3", MemAddr, Memdata);
        end
        tick();
    endtask

    task automatic test_wrap;
        int n = 0;
        int cyc = 0;
        logic acc;
        wlog.delete();
        ld_addr = 32'h400;
        while (n < 10 && cyc < 200) begin
            ld_valid = 1'($urandom_range(0, 1));
            st_valid = 1'b1;
            st_addr  = 32'h60 + 32'(4 * (n % 3));
            st_data  = 32'h100 + 32'(n);
            #1;
            checks++;
            if (sb_count > 3'd4) begin
                failures++;
                $display("FAIL wrap_cnt: cnt=%0d exp <=4", sb_count);
            end
            acc = st_ready;
            tick();
            if (acc) n++;
            cyc++;
        end
        st_valid = 1'b0;
        ld_valid = 1'b0;
        cyc = 0;
        while (sb_empty !== 1'b1 && cyc < 10) begin
            tick();
            cyc++;
        end
        checks++;
        if (sb_empty !== 1'b1 || n != 10) begin
            failures++;
            $display("FAIL wrap_timeout: empty=%0b stores=%0d exp 1 10", sb_empty, n);
        end
        checks++;
        if (wlog.size() != 10) begin
            failures++;
            $display("FAIL wrap_writes: got %0d exp 10", wlog.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (wlog[k] !== {32'h60 + 32'(4 * (k % 3)), 32'h100 + 32'(k)}) begin
                    failures++;
                    $display("FAIL wrap_order%0d: got %h exp %h", k, wlog[k],
                             {32'h60 + 32'(4 * (k % 3)), 32'h100 + 32'(k)});
                end
            end
        end
        checks++;
        if (mem[24] !== 32'h109 || mem[25] !== 32'h107 || mem[26] !== 32'h108) begin
            failures++;
            $display("FAIL wrap_mem: %h %h %h exp 00000109 00000107 00000108",
                     mem[24], mem[25], mem[26]);
        end
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_fill();
        test_forwarding();
        test_simultaneous();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
